// File: rtl/dmem_pkg.sv
// Shared types for the MEM-stage data memory: access size encodings, the
// controller state enum and the alignment rule used by every access.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        RESP = 2'b10
    } state_e;

    // A reserved size is treated as misaligned so it never touches storage.
    function automatic logic misaligned(input size_e sz, input logic [1:0] lane);
        case (sz)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return lane[0];
            SZ_WORD: return |lane;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: merges store data into the old word and
// extracts/extends load data from the addressed lanes (little-endian).
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    input  size_e       size_i,
    input  logic [1:0]  lane_i,
    input  logic        unsigned_i,
    output logic [31:0] merged_o,
    output logic [31:0] rdata_o
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        merged_o = word_i;
        case (size_i)
            SZ_BYTE: merged_o[{lane_i, 3'b000} +: 8]        = wdata_i[7:0];
            SZ_HALF: merged_o[{lane_i[1], 4'b0000} +: 16]   = wdata_i[15:0];
            SZ_WORD: merged_o                               = wdata_i;
            default: merged_o                               = word_i;
        endcase
    end

    always_comb begin
        ld_byte = word_i[{lane_i, 3'b000} +: 8];
        ld_half = word_i[{lane_i[1], 4'b0000} +: 16];
        rdata_o = 32'h0;
        case (size_i)
            SZ_BYTE: rdata_o = unsigned_i ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            SZ_HALF: rdata_o = unsigned_i ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
            SZ_WORD: rdata_o = word_i;
            default: rdata_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// MEM-stage data memory: request/ready handshake with LATENCY wait states,
// byte/half/word access, misalignment faulting and a stall to the hazard unit.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 0,
    parameter int AWIDTH  = $clog2(DEPTH) + 2
) (
    input  logic              m_clk,
    input  logic              m_rst,
    input  logic              m_i_req,
    input  logic              m_i_we,
    input  logic [1:0]        m_i_size,
    input  logic              m_i_unsigned,
    input  logic [AWIDTH-1:0] m_i_addr,
    input  logic [31:0]       m_i_wdata,
    output logic [31:0]       m_o_rdata,
    output logic              m_o_ready,
    output logic              m_o_fault,
    output logic              m_o_stall
);

    localparam int          IW  = AWIDTH - 2;
    localparam logic [3:0]  LAT = 4'(LATENCY);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    size_e             size_q, size_d;
    logic              uns_q, uns_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              ready_q, ready_d;
    logic              fault_q, fault_d;

    logic [31:0]       mem_q [DEPTH];
    logic              mem_we;
    logic [IW-1:0]     idx;
    logic [1:0]        lane;
    logic              bad;
    logic [31:0]       cur_word, st_word, ld_data;

    assign idx      = addr_q[AWIDTH-1:2];
    assign lane     = addr_q[1:0];
    assign cur_word = mem_q[idx];
    assign bad      = misaligned(size_q, lane);

    dmem_lane_align u_align (
        .word_i     (cur_word),
        .wdata_i    (wdata_q),
        .size_i     (size_q),
        .lane_i     (lane),
        .unsigned_i (uns_q),
        .merged_o   (st_word),
        .rdata_o    (ld_data)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = 32'h0;
        ready_d = 1'b0;
        fault_d = 1'b0;
        mem_we  = 1'b0;
        case (state_q)
            BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    // The access happens on the edge into RESP, so a load
                    // accepted during RESP already sees this store.
                    state_d = RESP;
                    ready_d = 1'b1;
                    fault_d = bad;
                    rdata_d = (bad || we_q) ? 32'h0 : ld_data;
                    mem_we  = we_q && !bad;
                end
            end
            default: begin
                state_d = IDLE;
                if (m_i_req) begin
                    state_d = BUSY;
                    cnt_d   = LAT;
                    we_d    = m_i_we;
                    size_d  = size_e'(m_i_size);
                    uns_d   = m_i_unsigned;
                    addr_d  = m_i_addr;
                    wdata_d = m_i_wdata;
                end
            end
        endcase
    end

    always_ff @(posedge m_clk or negedge m_rst) begin
        if (!m_rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            size_q  <= SZ_BYTE;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            ready_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            fault_q <= fault_d;
        end
    end

    // Storage resets to word i = i so loads are predictable without preloading.
    always_ff @(posedge m_clk or negedge m_rst) begin
        if (!m_rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'(i);
        end else if (mem_we) begin
            mem_q[idx] <= st_word;
        end
    end

    assign m_o_rdata = rdata_q;
    assign m_o_ready = ready_q;
    assign m_o_fault = fault_q;
    assign m_o_stall = m_i_req & ~ready_q;

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Parametrised, byte-addressed data memory for the MEM stage of the MIPS pipeline. It supports byte, halfword and word loads and stores, with sign or zero extension on loads. A request/ready handshake with a configurable number of wait states lets the memory model slow storage. While an access is in flight the block drives a stall to the hazard unit, and it flags misaligned accesses instead of performing them.

## Interface
Parameters:
- DEPTH, 256: number of 32-bit words. Must be a power of two and at least 4.
- LATENCY, 0: extra wait cycles per access, range 0–15.
- AWIDTH, $clog2(DEPTH)+2: byte-address width. Derived; do not override.

Ports:
- m_clk  in  1  clock; all state updates on the rising edge
- m_rst  in  1  reset, asynchronous, active-low
- m_i_req  in  1  access request; held high until m_o_ready
- m_i_we  in  1  1 = store, 0 = load
- m_i_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- m_i_unsigned  in  1  load extension: 1 = zero-extend, 0 = sign-extend
- m_i_addr  in  AWIDTH  byte address
- m_i_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- m_o_rdata  out  32  load result, valid only while m_o_ready=1
- m_o_ready  out  1  one-cycle completion pulse
- m_o_fault  out  1  misalignment flag, valid with m_o_ready
- m_o_stall  out  1  m_i_req & ~m_o_ready (combinational)

## Operation
- Storage: DEPTH × 32 bits, little-endian. Word index is addr[AWIDTH-1:2]; byte lane is addr[1:0].
- Reset while m_rst=0:
  - word i ← i
  - state IDLE, wait counter 0
  - m_o_rdata=0, m_o_ready=0, m_o_fault=0
  - any pending access is aborted and its write discarded.
- States:
  - IDLE: if m_i_req=1, latch we, size, unsigned, addr and wdata; load counter with LATENCY; go to BUSY.
  - BUSY: if counter≠0, decrement. If counter=0, perform the access and go to RESP.
  - RESP: m_o_ready=1 for exactly one cycle. If m_i_req=1, accept the next request as in IDLE and go to BUSY; otherwise go to IDLE.
- Misaligned access: half with addr[0]=1, word with addr[1:0]≠0, or size=11.
  - No memory write.
  - m_o_rdata=0 and m_o_fault=1 in RESP.
- Stores read-modify-write only the addressed lanes:
  - byte writes lane addr[1:0] from wdata[7:0]
  - half writes lanes {addr[1],0} and {addr[1],1} from wdata[15:0]
  - word writes all four lanes
  - Other lanes keep their value. A store returns m_o_rdata=0.
- Loads extract the addressed lane(s), right-align them, and extend to 32 bits according to m_i_unsigned. Word loads ignore m_i_unsigned.
- Inputs are used only at the accept edge (IDLE or RESP with req=1). Changes to them afterwards have no effect on the access in flight.

## Timing
- Request sampled at edge E0; m_o_ready is high in the cycle after edge E0+LATENCY+1.
  - LATENCY=0: ready in the 2nd cycle after the request is first presented.
  - Throughput: one access per LATENCY+2 cycles with back-to-back requests.
- m_o_stall stays high from the cycle req rises until the ready cycle, inclusive of neither the cycle before req nor the ready cycle itself.
- Store data is visible to a load accepted in or after that store's RESP cycle.
- m_rst asserted mid-BUSY: outputs clear immediately (asynchronously) and the access is lost. The requester must re-issue it after reset.
- m_i_req dropped mid-access is a protocol violation. The block still completes the access and pulses ready once.

## Structure
- Package dmem_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_RSVD
  - state enum {IDLE, BUSY, RESP}
  - the misalignment-check function
- Sub-module dmem_lane_align is combinational. It has two paths:
  - store-merge: old word, wdata, size, lane → new word
  - load-extract: word, size, lane, unsigned → rdata
- Top level contains the FSM, counter, latch registers and storage array.

## Test plan
- Reset, then a word load at address 0x10, LATENCY=0 → rdata=0x00000004, fault=0, ready pulse 2 cycles after req rises.
- sb 0x80 to address 0x21, then lb at 0x21 → 0xFFFFFF80; lbu at 0x21 → 0x00000080; lw at 0x20 → 0x00008008.
- sh 0xBEEF to address 0x32, then lh → 0xFFFFBEEF; lw at 0x30 → 0xBEEF000C.
- lw at 0x06 and sh at 0x05 → fault=1, rdata=0, and word 1 is unchanged (load of 0x04 returns 0x00000001).
- LATENCY=3 with 3 back-to-back loads → one ready pulse every 5 cycles, and stall high in every other cycle.
- Reset asserted in the 2nd BUSY cycle of sw 0xDEADBEEF to address 0x40 → after release, lw at 0x40 returns 0x00000010.
